// File: rtl/load_store_unit.sv
// Word-memory load/store initiator: byte/half/word access with sign/zero extension and RMW stores.
// Define LSU_MISALIGN_ERR_EN to flag misaligned half/word accesses as errors.
module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic              store_q, store_d;
  logic              uns_q, uns_d;
  logic [1:0]        size_q, size_d;
  logic [1:0]        off_q, off_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [31:0]       mwdata_q, mwdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic        mis;
  logic        bad;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] ext;
  logic [31:0] merge;

`ifdef LSU_MISALIGN_ERR_EN
  assign mis = (req_size == 2'b01 && req_addr[0])
            || (req_size == 2'b10 && req_addr[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif

  assign bad = (req_size == 2'b11) || mis;

  always_comb begin
    lane_b = mem_rdata[{off_q, 3'b000} +: 8];
    lane_h = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ext    = mem_rdata;
    unique case (1'b1)
      size_q == 2'b00: ext = {{24{~uns_q & lane_b[7]}}, lane_b};
      size_q == 2'b01: ext = {{16{~uns_q & lane_h[15]}}, lane_h};
      default:         ext = mem_rdata;
    endcase
  end

  // Sub-word store: replace only the addressed lane(s) of the word just read.
  always_comb begin
    merge = mem_rdata;
    if (size_q == 2'b00) begin
      merge[{off_q, 3'b000} +: 8] = wdata_q[7:0];
    end else if (off_q[1]) begin
      merge[31:16] = wdata_q;
    end else begin
      merge[15:0] = wdata_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    store_d  = store_q;
    uns_d    = uns_q;
    size_d   = size_q;
    off_d    = off_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    mwdata_d = mwdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          store_d = req_store;
          uns_d   = req_unsigned;
          size_d  = req_size;
          off_d   = req_addr[1:0];
          addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
          wdata_d = req_wdata[15:0];
          err_d   = bad;
          if (bad) begin
            rdata_d = '0;
            state_d = DONE;
          end else if (req_store && req_size == 2'b10) begin
            mwdata_d = req_wdata;
            state_d  = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        if (store_q) begin
          mwdata_d = merge;
          state_d  = WR;
        end else begin
          rdata_d = ext;
          state_d = DONE;
        end
      end
      WR: begin
        rdata_d = '0;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store_q  <= 1'b0;
      uns_q    <= 1'b0;
      size_q   <= 2'b00;
      off_q    <= 2'b00;
      addr_q   <= '0;
      wdata_q  <= '0;
      mwdata_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      store_q  <= store_d;
      uns_q    <= uns_d;
      size_q   <= size_d;
      off_q    <= off_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      mwdata_q <= mwdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == DONE);
  assign mem_read   = (state_q == RD);
  assign mem_write  = (state_q == WR);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = mwdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word memory model.
// Runs against the default build; the misaligned-word case follows LSU_MISALIGN_ERR_EN.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;

  logic [31:0] mem [64];
  int n_cmp = 0;
  int n_bad = 0;
  int n_resp = 0;
  int n_acc = 0;
  int n_rd = 0;
  int n_wr = 0;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;
    if (resp_valid) n_resp++;
    if (req_valid && req_ready) n_acc++;
    if (mem_read) n_rd++;
    if (mem_write) n_wr++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic st, input logic [1:0] sz,
                       input logic un, input logic [31:0] a,
                       input logic [31:0] d);
    req_valid    = 1'b1;
    req_store    = st;
    req_size     = sz;
    req_unsigned = un;
    req_addr     = a;
    req_wdata    = d;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic load(input string tag, input logic [1:0] sz,
                      input logic un, input logic [31:0] a,
                      input logic [31:0] exp);
    issue(1'b0, sz, un, a, 32'h0);
    chk({tag, "_rd"}, {31'b0, mem_read}, 32'd1);
    chk({tag, "_addr"}, mem_addr, {a[31:2], 2'b00});
    tick();
    chk({tag, "_rv"}, {31'b0, resp_valid}, 32'd1);
    chk({tag, "_data"}, resp_rdata, exp);
    chk({tag, "_err"}, {31'b0, resp_err}, 32'd0);
    tick();
    chk({tag, "_idle"}, {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_store = 1'b0;
    req_size = 2'b00;
    req_unsigned = 1'b0;
    req_addr = 32'h0;
    req_wdata = 32'h0;
    #23;
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_ctl", {28'b0, resp_valid, resp_err, mem_read, mem_write}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    rst_n = 1'b1;
    tick();

    // word store
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    chk("sw_wr", {30'b0, mem_read, mem_write}, 32'd1);
    chk("sw_addr", mem_addr, 32'h10);
    chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
    chk("sw_busy", {31'b0, req_ready}, 32'd0);
    tick();
    chk("sw_rv", {31'b0, resp_valid}, 32'd1);
    chk("sw_err", {31'b0, resp_err}, 32'd0);
    chk("sw_rdata", resp_rdata, 32'h0);
    chk("sw_mem", mem[4], 32'hDEADBEEF);
    tick();
    chk("sw_idle", {31'b0, resp_valid}, 32'd0);

    // sub-word loads
    mem[4] = 32'h80FF1234;
    load("lb13", 2'b00, 1'b0, 32'h13, 32'hFFFFFF80);
    load("lbu13", 2'b00, 1'b1, 32'h13, 32'h00000080);
    load("lh10", 2'b01, 1'b0, 32'h10, 32'h00001234);
    load("lh12", 2'b01, 1'b0, 32'h12, 32'hFFFF80FF);
    load("lhu12", 2'b01, 1'b1, 32'h12, 32'h000080FF);
    load("lbu11", 2'b00, 1'b1, 32'h11, 32'h00000012);
    load("lw10", 2'b10, 1'b0, 32'h10, 32'h80FF1234);

    // read-modify-write half store
    mem[5] = 32'h11223344;
    issue(1'b1, 2'b01, 1'b0, 32'h16, 32'h0000ABCD);
    chk("sh_rd", {30'b0, mem_read, mem_write}, 32'd2);
    chk("sh_addr", mem_addr, 32'h14);
    tick();
    chk("sh_wr", {30'b0, mem_read, mem_write}, 32'd1);
    chk("sh_wdata", mem_wdata, 32'hABCD3344);
    chk("sh_rv0", {31'b0, resp_valid}, 32'd0);
    tick();
    chk("sh_rv", {31'b0, resp_valid}, 32'd1);
    chk("sh_mem", mem[5], 32'hABCD3344);
    tick();

    // byte store lane 1
    issue(1'b1, 2'b00, 1'b0, 32'h15, 32'hFFFFFF77);
    tick();
    chk("sb_wdata", mem_wdata, 32'hABCD7744);
    tick();
    chk("sb_rv", {31'b0, resp_valid}, 32'd1);
    chk("sb_mem", mem[5], 32'hABCD7744);
    tick();

    // misaligned word
    mem[8] = 32'hCAFEF00D;
`ifdef LSU_MISALIGN_ERR_EN
    issue(1'b0, 2'b10, 1'b0, 32'h21, 32'h0);
    chk("mis_rv", {31'b0, resp_valid}, 32'd1);
    chk("mis_err", {31'b0, resp_err}, 32'd1);
    chk("mis_rd", {31'b0, mem_read}, 32'd0);
    tick();
`else
    load("lw21", 2'b10, 1'b0, 32'h21, 32'hCAFEF00D);
`endif

    // illegal size
    n_rd = 0;
    n_wr = 0;
    issue(1'b1, 2'b11, 1'b0, 32'h20, 32'h12345678);
    chk("ill_rv", {31'b0, resp_valid}, 32'd1);
    chk("ill_err", {31'b0, resp_err}, 32'd1);
    chk("ill_rdata", resp_rdata, 32'h0);
    tick();
    chk("ill_noacc", n_rd + n_wr, 0);
    chk("ill_hold", {31'b0, resp_err}, 32'd1);
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    chk("err_clr", {31'b0, resp_err}, 32'd0);
    tick();
    chk("lw20", resp_rdata, 32'hCAFEF00D);
    tick();

    // reset during RD of a byte store
    mem[2] = 32'h55555555;
    n_resp = 0;
    issue(1'b1, 2'b00, 1'b0, 32'h08, 32'h000000AA);
    chk("rst_mid_rd", {31'b0, mem_read}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_drop", {30'b0, mem_read, mem_write}, 32'd0);
    tick();
    tick();
    #2 rst_n = 1'b1;
    tick();
    chk("rst_mid_ready", {31'b0, req_ready}, 32'd1);
    tick();
    chk("rst_mid_noresp", n_resp, 0);
    chk("rst_mid_mem", mem[2], 32'h55555555);

    // held request: accepted only in IDLE
    n_resp = 0;
    n_acc = 0;
    n_rd = 0;
    req_valid = 1'b1;
    req_store = 1'b0;
    req_size = 2'b10;
    req_unsigned = 1'b0;
    req_addr = 32'h10;
    for (int i = 0; i < 20 && n_acc < 3; i++) tick();
    req_valid = 1'b0;
    chk("held_acc", n_acc, 3);
    for (int i = 0; i < 4; i++) tick();
    chk("held_resp", n_resp, 3);
    chk("held_rd", n_rd, 3);
    chk("held_acc_end", n_acc, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
